// File: rtl/scnn_pkg.sv
// Shared types and defaults for the SCNN compressed-operand producer.
// Sub-modules take explicit width parameters; these are the defaults.
package scnn_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IDX_W_DEF  = 8;
    localparam int MAX_NZ_DEF = 16;

    localparam logic [IDX_W_DEF-1:0] IDX_PAD = '1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] val;
        logic [IDX_W_DEF-1:0]  idx;
    } comp_slot_t;

endpackage

// File: rtl/scnn_nz_slot_buf.sv
// MAX_NZ-entry register file written by slot number.
// A synchronous clear returns every slot to value 0 / index all-ones.
module scnn_nz_slot_buf #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8,
    parameter int MAX_NZ = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_wr_sel,
    input  logic [DATA_W-1:0]        i_wr_val,
    input  logic [IDX_W-1:0]         i_wr_idx,
    output logic [MAX_NZ*DATA_W-1:0] o_vals,
    output logic [MAX_NZ*IDX_W-1:0]  o_idx
);

    generate
        for (genvar gi = 0; gi < MAX_NZ; gi++) begin : g_slot
            logic [DATA_W-1:0] r_val;
            logic [IDX_W-1:0]  r_idx;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_val <= '0;
                    r_idx <= '1;
                end else if (i_clear) begin
                    r_val <= '0;
                    r_idx <= '1;
                end else if (i_wr_en && (i_wr_sel == IDX_W'(gi))) begin
                    r_val <= i_wr_val;
                    r_idx <= i_wr_idx;
                end
            end

            assign o_vals[gi*DATA_W +: DATA_W] = r_val;
            assign o_idx[gi*IDX_W +: IDX_W]    = r_idx;
        end
    endgenerate

endmodule

// File: rtl/scnn_sparse_compressor.sv
// Scans a dense operand stream and hands out chunks of up to MAX_NZ
// non-zero values with their absolute dense positions.
module scnn_sparse_compressor
    import scnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int MAX_NZ = MAX_NZ_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [IDX_W-1:0]         i_dense_len,
    input  logic                     i_in_valid,
    input  logic [DATA_W-1:0]        i_in_data,
    output logic                     o_in_ready,
    output logic [MAX_NZ*DATA_W-1:0] o_comp_vals,
    output logic [MAX_NZ*IDX_W-1:0]  o_comp_idx,
    output logic [IDX_W-1:0]         o_num_nz,
    output logic [IDX_W-1:0]         o_chunk_base,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_out_last,
    output logic                     o_busy
);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_last_pos;
    logic [IDX_W-1:0] r_pos;
    logic [IDX_W-1:0] r_count;
    logic [IDX_W-1:0] r_chunk_base;
    logic             r_last;

    logic w_start;
    logic w_accept;
    logic w_nz;
    logic w_end;
    logic w_full;
    logic w_emit_hs;
    logic w_clear;

    assign w_start   = (r_state == IDLE) && i_start;
    assign w_accept  = (r_state == COLLECT) && i_in_valid;
    assign w_nz      = (i_in_data != '0);
    assign w_end     = (r_pos == r_last_pos);
    assign w_full    = w_nz && (r_count == IDX_W'(MAX_NZ - 1));
    assign w_emit_hs = (r_state == EMIT) && i_out_ready;
    assign w_clear   = w_start || (w_emit_hs && !r_last);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = COLLECT;
            COLLECT: if (w_accept && (w_end || w_full)) w_state_next = EMIT;
            EMIT:    if (i_out_ready) w_state_next = r_last ? IDLE : COLLECT;
            default: w_state_next = IDLE;
        endcase
    end

    // Storing len-1 makes a dense_len of 0 naturally mean 2**IDX_W elements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_pos   <= '0;
            r_pos        <= '0;
            r_count      <= '0;
            r_chunk_base <= '0;
            r_last       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_last_pos   <= i_dense_len - 1'b1;
                r_pos        <= '0;
                r_count      <= '0;
                r_chunk_base <= '0;
                r_last       <= 1'b0;
            end else if (w_accept) begin
                r_pos <= r_pos + 1'b1;
                if (w_nz)  r_count <= r_count + 1'b1;
                if (w_end) r_last  <= 1'b1;
            end else if (w_emit_hs && !r_last) begin
                r_count      <= '0;
                r_chunk_base <= r_pos;
            end
        end
    end

    scnn_nz_slot_buf #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .MAX_NZ (MAX_NZ)
    ) u_slot_buf (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_wr_en  (w_accept && w_nz),
        .i_wr_sel (r_count),
        .i_wr_val (i_in_data),
        .i_wr_idx (r_pos),
        .o_vals   (o_comp_vals),
        .o_idx    (o_comp_idx)
    );

    assign o_in_ready   = (r_state == COLLECT);
    assign o_out_valid  = (r_state == EMIT);
    assign o_out_last   = (r_state == EMIT) && r_last;
    assign o_busy       = (r_state != IDLE);
    assign o_num_nz     = r_count;
    assign o_chunk_base = r_chunk_base;

endmodule

// File: tb/tb_scnn_sparse_compressor.sv
// Directed bench for scnn_sparse_compressor: fixed vectors with
// hand-worked chunk contents, one printed line per chunk.
module tb_scnn_sparse_compressor;
    import scnn_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [7:0]   i_dense_len;
    logic         i_in_valid;
    logic [15:0]  i_in_data;
    logic         o_in_ready;
    logic [255:0] o_comp_vals;
    logic [127:0] o_comp_idx;
    logic [7:0]   o_num_nz;
    logic [7:0]   o_chunk_base;
    logic         o_out_valid;
    logic         i_out_ready;
    logic         o_out_last;
    logic         o_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]  vec [256];
    logic [255:0] ev;
    logic [127:0] ei;

    always #5 clk = ~clk;

    scnn_sparse_compressor dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_dense_len  (i_dense_len),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_comp_vals  (o_comp_vals),
        .o_comp_idx   (o_comp_idx),
        .o_num_nz     (o_num_nz),
        .o_chunk_base (o_chunk_base),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_last   (o_out_last),
        .o_busy       (o_busy)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pad_exp();
        ev = '0;
        ei = '1;
    endtask

    task automatic set_slot(input int s, input comp_slot_t sl);
        ev[s*16 +: 16] = sl.val;
        ei[s*8 +: 8]   = sl.idx;
    endtask

    // All tasks begin and end on a falling edge.
    task automatic start_vec(input int len);
        i_start     = 1'b1;
        i_dense_len = 8'(len);
        @(negedge clk);
        i_start     = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d);
        int t = 0;
        i_in_valid = 1'b1;
        i_in_data  = d;
        while (!o_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_in_ready) chk("feed_timeout", 256'(o_in_ready), 256'(1));
        @(negedge clk);
    endtask

    task automatic feed_all(input int len);
        for (int i = 0; i < len; i++) feed(vec[i]);
        i_in_valid = 1'b0;
    endtask

    task automatic get_chunk(input string tag, input logic [255:0] xv, input logic [127:0] xi,
                             input int nz, input int base, input logic last);
        int t = 0;
        while (!o_out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, 256'(o_out_valid), 256'(1));
        if (!o_out_valid) return;
        chk({tag, "_vals"},  o_comp_vals, xv);
        chk({tag, "_idx"},   256'(o_comp_idx), 256'(xi));
        chk({tag, "_nz"},    256'(o_num_nz), 256'(nz));
        chk({tag, "_base"},  256'(o_chunk_base), 256'(base));
        chk({tag, "_last"},  256'(o_out_last), 256'(last));
        chk({tag, "_inrdy"}, 256'(o_in_ready), 256'(0));
        $display("chunk %s: nz=%0d base=%0d last=%0b", tag, o_num_nz, o_chunk_base, o_out_last);
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_dense_len = '0;
        i_in_valid = 1'b0;
        i_in_data = '0;
        i_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_inrdy", 256'(o_in_ready), 256'(0));
        chk("rst_valid", 256'(o_out_valid), 256'(0));
        chk("rst_last",  256'(o_out_last), 256'(0));
        chk("rst_busy",  256'(o_busy), 256'(0));
        chk("rst_nz",    256'(o_num_nz), 256'(0));
        chk("rst_base",  256'(o_chunk_base), 256'(0));
        chk("rst_vals",  o_comp_vals, 256'(0));
        chk("rst_idx",   256'(o_comp_idx), 256'({16{IDX_PAD}}));
        rst = 1'b0;
        @(negedge clk);

        // Sparse vector, one chunk; out_valid one cycle after the last accept.
        vec[0] = 0; vec[1] = 5; vec[2] = 0; vec[3] = 0;
        vec[4] = 7; vec[5] = 0; vec[6] = 0; vec[7] = 3;
        start_vec(8);
        chk("t1_busy", 256'(o_busy), 256'(1));
        feed_all(8);
        chk("t1_latency", 256'(o_out_valid), 256'(1));
        pad_exp();
        set_slot(0, '{val: 16'd5, idx: 8'd1});
        set_slot(1, '{val: 16'd7, idx: 8'd4});
        set_slot(2, '{val: 16'd3, idx: 8'd7});
        get_chunk("t1", ev, ei, 3, 0, 1'b1);
        chk("t1_idle", 256'(o_busy), 256'(0));

        // 40 dense non-zeros split 16/16/8.
        for (int i = 0; i < 40; i++) vec[i] = 16'(i + 1);
        start_vec(40);
        fork
            feed_all(40);
            begin
                for (int k = 0; k < 3; k++) begin
                    int nzk;
                    nzk = (k < 2) ? 16 : 8;
                    pad_exp();
                    for (int j = 0; j < nzk; j++)
                        set_slot(j, '{val: 16'(16*k + j + 1), idx: 8'(16*k + j)});
                    get_chunk($sformatf("t2c%0d", k), ev, ei, nzk, 16*k, k == 2);
                end
            end
        join
        chk("t2_idle", 256'(o_busy), 256'(0));

        // Chunk fills on the final element: a single last chunk, nothing after.
        start_vec(16);
        pad_exp();
        for (int j = 0; j < 16; j++) set_slot(j, '{val: 16'(j + 1), idx: 8'(j)});
        fork
            feed_all(16);
            get_chunk("t3", ev, ei, 16, 0, 1'b1);
        join
        repeat (3) @(negedge clk);
        chk("t3_novalid", 256'(o_out_valid), 256'(0));
        chk("t3_idle", 256'(o_busy), 256'(0));

        // All-zero vector.
        for (int i = 0; i < 10; i++) vec[i] = 16'd0;
        start_vec(10);
        feed_all(10);
        pad_exp();
        get_chunk("t4", ev, ei, 0, 0, 1'b1);
        chk("t4_idle", 256'(o_busy), 256'(0));

        // Back-pressure in EMIT: stalled input and a stray start are ignored.
        vec[0] = 16'd1; vec[1] = 16'd2; vec[2] = 16'd3;
        start_vec(3);
        feed_all(3);
        pad_exp();
        set_slot(0, '{val: 16'd1, idx: 8'd0});
        set_slot(1, '{val: 16'd2, idx: 8'd1});
        set_slot(2, '{val: 16'd3, idx: 8'd2});
        i_in_valid = 1'b1;
        i_in_data = 16'd99;
        i_start = 1'b1;
        i_dense_len = 8'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t5_hold%0d_valid", c), 256'(o_out_valid), 256'(1));
            chk($sformatf("t5_hold%0d_inrdy", c), 256'(o_in_ready), 256'(0));
            chk($sformatf("t5_hold%0d_vals", c), o_comp_vals, ev);
            chk($sformatf("t5_hold%0d_nz", c), 256'(o_num_nz), 256'(3));
        end
        i_in_valid = 1'b0;
        i_start = 1'b0;
        get_chunk("t5", ev, ei, 3, 0, 1'b1);
        chk("t5_idle", 256'(o_busy), 256'(0));

        // Reset in the middle of a chunk discards it.
        vec[0] = 16'd9; vec[1] = 16'd8; vec[2] = 16'd7;
        start_vec(8);
        feed(vec[0]);
        feed(vec[1]);
        feed(vec[2]);
        i_in_valid = 1'b0;
        chk("t6_prebusy", 256'(o_busy), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy",  256'(o_busy), 256'(0));
        chk("t6_nz",    256'(o_num_nz), 256'(0));
        chk("t6_inrdy", 256'(o_in_ready), 256'(0));
        chk("t6_vals",  o_comp_vals, 256'(0));
        chk("t6_idx",   256'(o_comp_idx), 256'({16{IDX_PAD}}));
        rst = 1'b0;
        @(negedge clk);
        vec[0] = 16'd0; vec[1] = 16'd4;
        start_vec(2);
        feed_all(2);
        pad_exp();
        set_slot(0, '{val: 16'd4, idx: 8'd1});
        get_chunk("t6", ev, ei, 1, 0, 1'b1);
        chk("t6_idle", 256'(o_busy), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
